// File: rtl/cfg_bitstream_serializer.sv
`default_nettype none
// ============================================================================
// cfg_bitstream_serializer
//   Byte-wide AXI-stream to 1-bit AXI-stream serializer for the fabric
//   configuration port. Optional CRC-8 via `define CFG_SER_CRC_EN.
// Revision: 1.0
// ============================================================================
module cfg_bitstream_serializer #(
    parameter int BYTE_WIDTH      = 8,
    parameter int MSB_FIRST       = 1,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [BYTE_WIDTH-1:0]      s_tdata,
    input  logic                       s_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tdata,
    output logic                       m_tlast,
    input  logic                       abort,
    output logic                       busy,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_bits,
    output logic [7:0]                 crc_value,
    output logic                       crc_valid
);

    localparam int                         IDX_W    = $clog2(BYTE_WIDTH);
    localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(BYTE_WIDTH - 1);
    localparam logic [FRAME_CNT_WIDTH-1:0] FB_MAX   = '1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [BYTE_WIDTH-1:0]   r_sreg;
    logic [BYTE_WIDTH-1:0]   w_shifted;
    logic [IDX_W-1:0]        r_bit_idx;
    logic                    r_last_flag;
    logic                    r_new_frame;
    logic                    w_shifting;
    logic                    w_bit_hs;
    logic                    w_last_bit;
    logic                    w_byte_hs;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign m_tdata   = r_sreg[BYTE_WIDTH-1];
            assign w_shifted = {r_sreg[BYTE_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign m_tdata   = r_sreg[0];
            assign w_shifted = {1'b0, r_sreg[BYTE_WIDTH-1:1]};
        end
    endgenerate

    assign w_shifting = (state == SHIFT);
    assign m_tvalid   = w_shifting;
    assign busy       = w_shifting;
    assign w_last_bit = (r_bit_idx == LAST_IDX);
    assign w_bit_hs   = w_shifting & m_tready;
    assign w_byte_hs  = s_tvalid & s_tready;
    // last_flag survives into EMPTY, so qualify with the SHIFT state
    assign m_tlast    = w_shifting & r_last_flag & w_last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_tready   = 1'b0;
        if (!abort) begin
            s_tready = (state == EMPTY) | (w_bit_hs & w_last_bit);
        end
        case (state)
            EMPTY: if (w_byte_hs) state_next = SHIFT;
            SHIFT: if (w_bit_hs && w_last_bit && !w_byte_hs) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (abort) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg      <= '0;
            r_bit_idx   <= '0;
            r_last_flag <= 1'b0;
            r_new_frame <= 1'b1;
            frame_bits  <= '0;
            frame_done  <= 1'b0;
        end else if (abort) begin
            r_sreg      <= '0;
            r_bit_idx   <= '0;
            r_last_flag <= 1'b0;
            r_new_frame <= 1'b1;
            frame_bits  <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= w_bit_hs & m_tlast;
            if (w_byte_hs) begin
                r_sreg      <= s_tdata;
                r_bit_idx   <= '0;
                r_last_flag <= s_tlast;
            end else if (w_bit_hs && !w_last_bit) begin
                r_sreg    <= w_shifted;
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_bit_hs) begin
                r_new_frame <= m_tlast;
                if (r_new_frame) begin
                    frame_bits <= FRAME_CNT_WIDTH'(1);
                end else if (frame_bits != FB_MAX) begin
                    frame_bits <= frame_bits + FRAME_CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef CFG_SER_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_next;

    assign w_crc_next = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ m_tdata) ? 8'h07 : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc     <= '0;
            crc_value <= '0;
            crc_valid <= 1'b0;
        end else if (abort) begin
            r_crc     <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (w_bit_hs) begin
                if (m_tlast) begin
                    crc_value <= w_crc_next;
                    crc_valid <= 1'b1;
                    r_crc     <= '0;
                end else begin
                    r_crc <= w_crc_next;
                end
            end
        end
    end
`else
    assign crc_value = '0;
    assign crc_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_bitstream_serializer.sv
`default_nettype none
// ============================================================================
// tb_cfg_bitstream_serializer
//   Directed self-checking bench: MSB-first DUT plus an LSB-first DUT with a
//   4-bit frame counter sharing the same stimulus.
// Revision: 1.0
// ============================================================================
module tb_cfg_bitstream_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tlast, m_tready, abort;
    logic [7:0]  s_tdata;

    logic        s_tready0, m_tvalid0, m_tdata0, m_tlast0, busy0, frame_done0, crc_valid0;
    logic [15:0] frame_bits0;
    logic [7:0]  crc_value0;
    logic        s_tready1, m_tvalid1, m_tdata1, m_tlast1, busy1, frame_done1, crc_valid1;
    logic [3:0]  frame_bits1;
    logic [7:0]  crc_value1;

    logic        sel;
    logic        o_s_tready, o_m_tvalid, o_m_tdata, o_m_tlast, o_busy, o_frame_done, o_crc_valid;
    logic [15:0] o_frame_bits;
    logic [7:0]  o_crc_value;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cfg_bitstream_serializer #(.BYTE_WIDTH(8), .MSB_FIRST(1), .FRAME_CNT_WIDTH(16)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready0), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .m_tvalid(m_tvalid0), .m_tready(m_tready), .m_tdata(m_tdata0),
        .m_tlast(m_tlast0), .abort(abort), .busy(busy0), .frame_done(frame_done0),
        .frame_bits(frame_bits0), .crc_value(crc_value0), .crc_valid(crc_valid0)
    );

    cfg_bitstream_serializer #(.BYTE_WIDTH(8), .MSB_FIRST(0), .FRAME_CNT_WIDTH(4)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready1), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .m_tvalid(m_tvalid1), .m_tready(m_tready), .m_tdata(m_tdata1),
        .m_tlast(m_tlast1), .abort(abort), .busy(busy1), .frame_done(frame_done1),
        .frame_bits(frame_bits1), .crc_value(crc_value1), .crc_valid(crc_valid1)
    );

    always_comb begin
        o_s_tready   = sel ? s_tready1   : s_tready0;
        o_m_tvalid   = sel ? m_tvalid1   : m_tvalid0;
        o_m_tdata    = sel ? m_tdata1    : m_tdata0;
        o_m_tlast    = sel ? m_tlast1    : m_tlast0;
        o_busy       = sel ? busy1       : busy0;
        o_frame_done = sel ? frame_done1 : frame_done0;
        o_crc_valid  = sel ? crc_valid1  : crc_valid0;
        o_crc_value  = sel ? crc_value1  : crc_value0;
        o_frame_bits = sel ? {12'd0, frame_bits1} : frame_bits0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives up to three bytes as one frame and checks every emitted bit.
    // rpat 0: m_tready always high; rpat 1: m_tready pattern 1,0,0 repeating.
    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nbytes, input int rpat,
                             input logic chk_crc, input logic [7:0] exp_crc);
        logic [7:0] bytes [3];
        logic [7:0] cur;
        logic       ebit, prev_stall, pd, pl, exp_cv;
        int         total, k, bi, cyc;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        total = nbytes * 8;
        k = 0; bi = 0; cyc = 0;
        prev_stall = 1'b0; pd = 1'b0; pl = 1'b0;
        while (k < total && cyc < 300) begin
            @(negedge clk);
            m_tready = (rpat == 0) ? 1'b1 : (cyc % 3 == 0);
            if (bi < nbytes) begin
                s_tvalid = 1'b1;
                s_tdata  = bytes[bi];
                s_tlast  = (bi == nbytes - 1);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("hold_tdata", o_m_tdata, pd);
                check("hold_tlast", o_m_tlast, pl);
            end
            if (cyc == 1) check("first_bit_latency", o_m_tvalid, 1);
            if (k > 0) check("no_gap_tvalid", o_m_tvalid, 1);
            if (o_m_tvalid) check("s_tready", o_s_tready, m_tready && (k % 8 == 7));
            if (o_m_tvalid && m_tready) begin
                cur  = bytes[k / 8];
                ebit = sel ? cur[k % 8] : cur[7 - (k % 8)];
                check("m_tdata", o_m_tdata, ebit);
                check("m_tlast", o_m_tlast, k == total - 1);
                k++;
            end
            if (s_tvalid && o_s_tready) bi++;
            prev_stall = o_m_tvalid && !m_tready;
            pd = o_m_tdata;
            pl = o_m_tlast;
            cyc++;
        end
        if (k < total) check("frame_timeout", k, total);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
`ifdef CFG_SER_CRC_EN
        exp_cv = 1'b1;
`else
        exp_cv  = 1'b0;
        exp_crc = 8'h00;
        chk_crc = 1'b1;
`endif
        check("frame_done_pulse", o_frame_done, 1);
        check("frame_bits", o_frame_bits, total);
        check("crc_valid_pulse", o_crc_valid, exp_cv);
        check("idle_after_frame", o_m_tvalid, 0);
        if (chk_crc) check("crc_value", o_crc_value, exp_crc);
        @(negedge clk);
        #1;
        check("frame_done_clear", o_frame_done, 0);
        check("crc_valid_clear", o_crc_valid, 0);
        check("frame_bits_hold", o_frame_bits, total);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        m_tready = 1'b0; abort = 1'b0; sel = 1'b0;
        #3;
        check("rst_s_tready", o_s_tready, 1);
        check("rst_m_tvalid", o_m_tvalid, 0);
        check("rst_m_tdata", o_m_tdata, 0);
        check("rst_m_tlast", o_m_tlast, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_frame_bits", o_frame_bits, 0);
        check("rst_crc_value", o_crc_value, 0);
        check("rst_crc_valid", o_crc_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single-byte frames; CRC-8 of 0xA5 is 0x72, of 0x00 is 0x00
        run_frame(8'hA5, 8'h00, 8'h00, 1, 0, 1'b1, 8'h72);
        run_frame(8'h00, 8'h00, 8'h00, 1, 0, 1'b1, 8'h00);

        // back-to-back bytes; the 4-bit counter on the LSB DUT saturates at 15
        run_frame(8'h01, 8'h80, 8'hFF, 3, 0, 1'b0, 8'h00);
        check("frame_bits_saturate", {28'd0, frame_bits1}, 15);

        // stalled output
        run_frame(8'hC3, 8'h00, 8'h00, 1, 1, 1'b0, 8'h00);

        // LSB-first ordering
        sel = 1'b1;
        run_frame(8'h01, 8'h00, 8'h00, 1, 0, 1'b0, 8'h00);
        sel = 1'b0;

        // abort after three bits of 0xFF
        @(negedge clk);
        m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 8'hFF; s_tlast = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_pre_valid", o_m_tvalid, 1);
            @(negedge clk);
        end
        abort = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h55; s_tlast = 1'b1;
        #1;
        check("abort_pre_bits", o_frame_bits, 3);
        check("abort_s_tready", o_s_tready, 0);
        @(negedge clk);
        abort = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        check("abort_m_tvalid", o_m_tvalid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_frame_bits", o_frame_bits, 0);
        check("abort_no_done", o_frame_done, 0);
        @(negedge clk);
        #1;
        check("abort_no_done_late", o_frame_done, 0);
        check("abort_no_crc_valid", o_crc_valid, 0);

        run_frame(8'h0F, 8'h00, 8'h00, 1, 0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
